// File: rtl/ftf_decoder_29.sv
// ftf_decoder_29: three-stage pipelined decoder for 29-bit FTF codewords.
// A codeword is decoded as the weighted sum of its set bits. Bit k carries weight F(k+1),
// using the Fibonacci numbers F(1) = F(2) = 1. Bit 0 therefore weighs 1 and bit 28 weighs F(29).
// The sum is formed in `FBLEN29+1 bits. Any sum above MAX_VALUE is flagged with range_err.
//
// Ports:
//   clock       sole clock, rising edge
//   reset       synchronous, active-high reset
//   codein      FTF codeword, bit 28 = MSB
//   code_valid  codein is valid this cycle
//   code_ready  decoder accepts codein this cycle (combinational)
//   dataout     decoded value (low `FBLEN29 bits of the sum)
//   data_valid  dataout/range_err valid
//   data_ready  downstream accepts dataout
//   range_err   decoded sum exceeds MAX_VALUE
//   err_count   saturating count of delivered range errors

`ifndef FBLEN29
`define FBLEN29 20
`endif
`ifndef FNS30
`define FNS30 832040
`endif

module ftf_decoder_29 #(
   parameter int unsigned MAX_VALUE = `FNS30 - 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [28:0]         codein,
   input  logic                code_valid,
   output logic                code_ready,
   output logic [`FBLEN29-1:0] dataout,
   output logic                data_valid,
   input  logic                data_ready,
   output logic                range_err,
   output logic [15:0]         err_count
);

   localparam int unsigned SW = `FBLEN29 + 1;

   // Fibonacci number F(n), where F(1) = F(2) = 1.
   // It is only called with constant arguments, so it folds to constants.
   function automatic logic [SW-1:0] fns(input int unsigned n);
      logic [SW-1:0] a;
      logic [SW-1:0] b;
      logic [SW-1:0] t;
      a = SW'(1);
      b = SW'(1);
      for (int unsigned i = 2; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return b;
   endfunction

   // Pipeline state
   logic          r_s1_valid;
   logic [28:0]   r_s1_code;
   logic          r_s2_valid;
   logic [SW-1:0] r_p0;
   logic [SW-1:0] r_p1;
   logic [SW-1:0] r_p2;
   logic          r_data_valid;
   logic [`FBLEN29-1:0] r_dataout;
   logic          r_range_err;
   logic [15:0]   r_err_count;

   logic          w_advance;
   logic [SW-1:0] w_p0;
   logic [SW-1:0] w_p1;
   logic [SW-1:0] w_p2;
   logic [SW-1:0] w_sum;
   logic          w_over;
   logic          w_err_xfer;

   // The whole pipeline moves in lockstep: it advances whenever the output slot is free
   // or is being drained this cycle.
   assign w_advance  = !r_data_valid || data_ready;
   assign code_ready = w_advance;

   // Partial sums over the three bit groups held in S1
   always_comb begin
      w_p0 = '0;
      w_p1 = '0;
      w_p2 = '0;
      for (int unsigned k = 0; k < 10; k++) begin
         if (r_s1_code[k]) w_p0 = w_p0 + fns(k + 1);
      end
      for (int unsigned k = 10; k < 20; k++) begin
         if (r_s1_code[k]) w_p1 = w_p1 + fns(k + 1);
      end
      for (int unsigned k = 20; k < 29; k++) begin
         if (r_s1_code[k]) w_p2 = w_p2 + fns(k + 1);
      end
   end

   // The maximum sum is F(31) - 1, so it fits in SW bits without overflow.
   assign w_sum      = r_p0 + r_p1 + r_p2;
   assign w_over     = 32'(w_sum) > MAX_VALUE;
   assign w_err_xfer = r_data_valid && data_ready && r_range_err;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_s1_valid   <= 1'b0;
         r_s1_code    <= '0;
         r_s2_valid   <= 1'b0;
         r_p0         <= '0;
         r_p1         <= '0;
         r_p2         <= '0;
         r_data_valid <= 1'b0;
         r_dataout    <= '0;
         r_range_err  <= 1'b0;
         r_err_count  <= '0;
      end else begin
         if (w_advance) begin
            // S1: a cycle without code_valid enters the pipeline as a bubble.
            r_s1_valid   <= code_valid;
            r_s1_code    <= codein;
            // S2
            r_s2_valid   <= r_s1_valid;
            r_p0         <= w_p0;
            r_p1         <= w_p1;
            r_p2         <= w_p2;
            // S3: output data only changes when a real word arrives.
            r_data_valid <= r_s2_valid;
            if (r_s2_valid) begin
               r_dataout   <= w_sum[`FBLEN29-1:0];
               r_range_err <= w_over;
            end
         end
         if (w_err_xfer && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
         end
      end
   end

   assign dataout    = r_dataout;
   assign data_valid = r_data_valid;
   assign range_err  = r_range_err;
   assign err_count  = r_err_count;

endmodule

// File: tb/tb_ftf_decoder_29.sv
// tb_ftf_decoder_29: self-checking bench for ftf_decoder_29.
// Expected words are queued at acceptance and compared on each output transfer.
module tb_ftf_decoder_29;

   localparam int unsigned DW   = 20;
   localparam int unsigned MAXV = 832039;

   logic          clock = 1'b0;
   logic          reset;
   logic [28:0]   codein;
   logic          code_valid;
   logic          code_ready;
   logic [DW-1:0] dataout;
   logic          data_valid;
   logic          data_ready;
   logic          range_err;
   logic [15:0]   err_count;

   always #5 clock = ~clock;

   ftf_decoder_29 #(.MAX_VALUE(MAXV)) dut (
      .clock      (clock),
      .reset      (reset),
      .codein     (codein),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .dataout    (dataout),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .range_err  (range_err),
      .err_count  (err_count)
   );

   typedef struct {
      logic [28:0]   code;
      logic [DW-1:0] data;
      logic          err;
   } vec_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   exp_t        sb[$];
   int          checks    = 0;
   int          failures  = 0;
   int unsigned fib[32];
   int unsigned exp_errs  = 0;
   int          delivered = 0;
   int          cyc       = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data  = '0;
   logic          prev_err   = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference decoder: weighted sum using F(k+1) for bit k
   function automatic exp_t model(input logic [28:0] c);
      int unsigned s = 0;
      exp_t r;
      for (int k = 0; k < 29; k++) begin
         if (c[k]) s += fib[k+1];
      end
      r.data = DW'(s);
      r.err  = (s > MAXV);
      return r;
   endfunction

   // Greedy Zeckendorf encoder over bits 28..1 (weights F(29)..F(2))
   function automatic logic [28:0] enc(input int unsigned x);
      logic [28:0] c = '0;
      int unsigned r = x;
      for (int k = 28; k >= 1; k--) begin
         if (r >= fib[k+1]) begin
            c[k] = 1'b1;
            r -= fib[k+1];
         end
      end
      return c;
   endfunction

   // Output monitor: sampled on the falling edge, so every value here is stable
   // for the next rising edge.
   always @(negedge clock) begin : mon
      exp_t e;
      if (!reset) begin
         if (prev_stall) begin
            check("hold_valid", data_valid, 1);
            check("hold_data", dataout, prev_data);
            check("hold_err", range_err, prev_err);
         end
         if (data_valid && !data_ready) check("code_ready_on_stall", code_ready, 0);
         if (!data_valid) check("code_ready_when_empty", code_ready, 1);
         if (data_valid && data_ready) begin
            check("err_count", err_count, exp_errs);
            if (sb.size() == 0) begin
               check("unexpected_output", sb.size(), 1);
            end else begin
               e = sb.pop_front();
               check("dataout", dataout, e.data);
               check("range_err", range_err, e.err);
               if (e.err && exp_errs != 65535) exp_errs++;
               delivered++;
            end
         end
         prev_stall = data_valid && !data_ready;
         prev_data  = dataout;
         prev_err   = range_err;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic send(input logic [28:0] w, input logic [DW-1:0] d, input logic e);
      bit ok = 1'b0;
      codein     = w;
      code_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clock);
         ok = code_ready;
         @(posedge clock);
         #1;
      end
      check("send_accept", ok, 1);
      if (ok) sb.push_back('{d, e});
      code_valid = 1'b0;
   endtask

   task automatic send_m(input logic [28:0] w);
      exp_t e = model(w);
      send(w, e.data, e.err);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clock);
         #1;
         n++;
      end
      check("drain_empty", sb.size(), 0);
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_reset();
      reset      = 1'b1;
      code_valid = 1'b0;
      @(posedge clock);
      #1;
      sb.delete();
      exp_errs = 0;
      reset    = 1'b0;
   endtask

   vec_t tbl[9];
   int   n_lat;
   int   t0;
   int   d0;
   int unsigned xs[5];

   initial begin
      fib[0] = 0;
      fib[1] = 1;
      fib[2] = 1;
      for (int n = 3; n < 32; n++) fib[n] = fib[n-1] + fib[n-2];

      tbl[0] = '{29'h0000000, 20'd0,      1'b0};
      tbl[1] = '{29'h0000001, 20'd1,      1'b0};
      tbl[2] = '{29'h0000002, 20'd1,      1'b0};
      tbl[3] = '{29'h0000005, 20'd3,      1'b0};
      tbl[4] = '{29'h10000000, 20'd514229, 1'b0};
      tbl[5] = '{29'h0AAAAAAA, 20'd514228, 1'b0};
      tbl[6] = '{29'h15555554, 20'd832039, 1'b0};  // exactly MAX_VALUE
      tbl[7] = '{29'h15555555, 20'd832040, 1'b1};  // MAX_VALUE + 1
      tbl[8] = '{29'h1FFFFFFF, 20'd297692, 1'b1};  // all ones, sum 1346268

      reset      = 1'b1;
      code_valid = 1'b0;
      codein     = '0;
      data_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("rst_data_valid", data_valid, 0);
      check("rst_err_count", err_count, 0);
      check("rst_code_ready", code_ready, 1);
      check("rst_dataout", dataout, 0);
      check("rst_range_err", range_err, 0);
      @(posedge clock);
      #1;

      // Table-driven vectors
      for (int i = 0; i < 9; i++) send(tbl[i].code, tbl[i].data, tbl[i].err);
      drain();
      @(negedge clock);
      check("err_count_after_table", err_count, 2);
      @(posedge clock);
      #1;

      // Single-bit sweep
      for (int k = 0; k < 29; k++) send(29'(1) << k, DW'(fib[k+1]), 1'b0);
      drain();

      // Latency from acceptance to data_valid
      send_m(29'h0000100);
      n_lat = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         n_lat++;
         if (data_valid) break;
      end
      check("latency", n_lat, 3);
      drain();

      // Back-pressure: five words with a four-cycle stall in the middle of the stream
      d0 = delivered;
      fork
         begin
            for (int i = 0; i < 5; i++) send_m(29'($urandom));
         end
         begin
            repeat (4) @(posedge clock);
            #1;
            data_ready = 1'b0;
            repeat (4) @(posedge clock);
            #1;
            data_ready = 1'b1;
         end
      join
      drain();
      check("backpressure_delivered", delivered - d0, 5);

      // Reset with three words in flight
      for (int i = 0; i < 3; i++) send_m(enc(i + 7));
      pulse_reset();
      @(negedge clock);
      check("midrst_data_valid", data_valid, 0);
      check("midrst_err_count", err_count, 0);
      check("midrst_code_ready", code_ready, 1);
      repeat (8) @(negedge clock);
      check("midrst_no_stale", delivered - d0, 5);
      @(posedge clock);
      #1;

      // Round trip through the reference encoder
      xs[0] = 0;
      xs[1] = 1;
      xs[2] = 2;
      xs[3] = 12345;
      xs[4] = MAXV;
      d0 = delivered;
      for (int i = 0; i < 5; i++) send(enc(xs[i]), DW'(xs[i]), 1'b0);
      t0 = cyc;
      for (int i = 0; i < 1000; i++) begin
         int unsigned x = $urandom_range(MAXV, 0);
         send(enc(x), DW'(x), 1'b0);
      end
      check("throughput_cycles", cyc - t0, 1000);
      drain();
      check("roundtrip_delivered", delivered - d0, 1005);
      @(negedge clock);
      check("roundtrip_err_count", err_count, 0);
      @(posedge clock);
      #1;

      // err_count saturation
      for (int i = 0; i < 70000; i++) send(29'h1FFFFFFF, 20'd297692, 1'b1);
      drain();
      @(negedge clock);
      check("err_count_saturated", err_count, 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ftf_decoder_29.md
FTF_DECODER_29 -- requirements
Module: ftf_decoder_29

Interface
REQ-001 SHALL have parameter MAX_VALUE, default `FNS30 - 1, the largest legal decoded value.
REQ-002 SHALL have ports (clock and reset first):
- clock  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high reset
- codein  input  29  FTF codeword, bit 28 = MSB
- code_valid  input  1  codein is valid this cycle
- code_ready  output  1  decoder accepts codein this cycle
- dataout  output  `FBLEN29  decoded value
- data_valid  output  1  dataout/range_err valid
- data_ready  input  1  downstream accepts dataout
- range_err  output  1  decoded sum exceeds MAX_VALUE
- err_count  output  16  saturating count of delivered range errors
REQ-003 SHALL use one clock; reset is synchronous and active-high, named reset; clock port named clock.

Function
REQ-004 SHALL decode codein as the weighted sum of set bits:
- bit k (k = 1..28) has weight `FNS(k+1)
- bit 0 has weight 1
- the sum is the inverse of the team's 29-bit FTF encoder.
REQ-005 SHALL form the sum in a width of `FBLEN29+1 bits, so no bit is lost before the range check.
REQ-006 SHALL implement a 3-stage pipeline:
- S1: register codein and code_valid
- S2: three registered partial sums over bits [9:0], [19:10] and [28:20]
- S3: final sum, dataout, range_err and data_valid.
REQ-007 SHALL have a latency of exactly 3 clock edges from an accepted word (code_valid && code_ready) to data_valid, when there is no stall.
REQ-008 SHALL define advance = !data_valid || data_ready.
- All stages (data and valid bits) update only when advance = 1.
- Otherwise all stages hold.
REQ-009 SHALL drive code_ready = advance, combinationally.
- A word offered while code_ready = 0 is not captured.
- The source holds it until code_ready = 1.
REQ-010 SHALL, when advance = 1 and code_valid = 0, insert a bubble into S1; bubbles propagate with valid = 0.
REQ-011 SHALL hold dataout, range_err and data_valid stable while data_valid = 1 and data_ready = 0.
REQ-012 SHALL assert range_err with the word when full sum > MAX_VALUE.
- dataout carries the low `FBLEN29 bits of the sum.
REQ-013 SHALL increment err_count by 1 on each output transfer (data_valid && data_ready) with range_err = 1.
- err_count saturates at 16'hFFFF with no wrap.
REQ-014 SHALL leave dataout and range_err unchanged when no valid word is in S3 (data_valid = 0); their value is don't-care for consumers.
REQ-015 SHALL treat a simultaneous output transfer and new input as a full-throughput shift: 1 word per cycle, sustained.
REQ-016 SHALL contain no combinational path from codein to dataout.

Reset
REQ-017 SHALL, on a clock edge with reset = 1:
- clear all stage valid bits, data_valid, dataout, range_err, err_count and partial sums to 0
- code_ready then follows REQ-009 (1 after reset).
REQ-018 SHALL discard words in flight when reset is asserted mid-operation; no data_valid appears for them.
REQ-019 SHALL give reset priority over advance and over err_count update in the same cycle.

Verification
REQ-020 Single-bit sweep: for k = 0..28, one word with only bit k set, data_ready = 1 -> dataout = 1 (k = 0) or `FNS(k+1) (k >= 1), range_err = 0, 3 cycles after acceptance.
REQ-021 Round trip: encoder output for x in {0, 1, 2, 12345, MAX_VALUE} -> dataout = x; also 1000 random x back-to-back -> one result per cycle, in order, err_count = 0.
REQ-022 Range error: codein = 29'h1FFFFFFF -> range_err = 1, dataout = low `FBLEN29 bits of the sum, err_count 0 -> 1 on transfer; 70000 such transfers -> err_count = 16'hFFFF.
REQ-023 Back-pressure: stream of 5 words, data_ready = 0 for 4 cycles mid-stream:
- code_ready = 0 while S3 holds a word
- outputs stable
- all 5 words delivered in order, none lost or duplicated.
REQ-024 Reset mid-stream: assert reset 1 cycle with 3 words in flight -> next cycle data_valid = 0, err_count = 0, code_ready = 1; no stale word emerges afterward.
